csr_file: RTL
=============

# csr_file

Machine-mode control and status register file for the single-cycle RV32 core. It consumes the CSR control bundle from the instruction decoder (`csr_alu_ctr`, `csr_we`, `csr2reg`) and supplies old CSR values for write-back. It executes the read-modify-write of Zicsr instructions and sequences traps: ECALL, EBREAK, MRET and the external interrupt. It also holds the free-running cycle and instret counters and drives the PC redirect on trap entry and return.

## Interface

Parameters:
- `MTVEC_RST`, 32'h0000_0000, reset value of mtvec.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr`  in  32  current instruction; [31:20] CSR address, [19:15] rs1/zimm field.
- `instr_valid`  in  1  instruction retires this cycle; low means bubble or stall, and no state changes except mcycle.
- `pc`  in  32  PC of `instr`.
- `rs1_data`  in  32  register-file rs1 value.
- `csr_alu_ctr`  in  3  bit0: 1 = zimm source, 0 = rs1 source; bits[2:1]: 00 write, 01 set, 10 clear, 11 reserved (no write).
- `csr_we`  in  1  CSR write request from the decoder.
- `csr2reg`  in  1  instruction is a CSR read.
- `ext_irq`  in  1  level external interrupt, already synchronous to `clk`.
- `csr_rdata`  out  32  old value of the addressed CSR; 0 when `csr2reg` is 0.
- `trap_taken`  out  1  PC redirect this cycle; core kills regwr/memwr when it is high.
- `trap_pc`  out  32  redirect target, valid when `trap_taken` is high.

## Operation

Implemented CSRs and their reset values. Any other address reads 0 and ignores writes.
- mstatus 0x300: MIE[3], MPIE[7] writable; MPP[12:11] reads 2'b11; all other bits read 0. Reset: MIE=0, MPIE=0.
- mie 0x304: only MEIE[11] writable. Reset 0.
- mtvec 0x305: bits[1:0] read 0 (direct mode only). Reset `MTVEC_RST` & ~3.
- mscratch 0x340: full 32 bits. Reset 0.
- mepc 0x341: bits[1:0] read 0. Reset 0.
- mcause 0x342: full 32 bits. Reset 0.
- mip 0x344: read-only; MEIP[11] = `ext_irq`.
- mcycle 0xB00 and mcycleh 0xB80: 64-bit counter, writable. Reset 0.
- minstret 0xB02 and minstreth 0xB82: 64-bit counter, writable. Reset 0.
- cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82: read-only aliases of the counters above.

CSR write path:
- Source operand: `rs1_data`, or zero-extended `instr[19:15]` when csr_alu_ctr[0]=1.
- New value: write = src; set = old | src; clear = old & ~src.
- Set and clear do not write when `instr[19:15]` == 0, even if `csr_we` is 1. Write ops always write.
- The write commits on the edge when `csr_we & instr_valid & ~trap_taken`.

Trap detection (only when `instr_valid`), in priority order:
1. Interrupt, when `ext_irq & MIE & MEIE`:
   - mepc←pc, mcause←32'h8000_000B.
   - Current instruction is not executed; any CSR write is dropped.
2. ECALL (32'h0000_0073): mepc←pc, mcause←11.
3. EBREAK (32'h0010_0073): mepc←pc, mcause←3.
4. MRET (32'h3020_0073): MIE←MPIE, MPIE←1; `trap_pc` = mepc.

Common trap rules:
- Trap entry (cases 1–3): MPIE←MIE, MIE←0, `trap_pc` = mtvec with bits[1:0] = 0.
- `trap_taken` is high in all four cases.

Counters:
- mcycle increments every cycle, including while `instr_valid` is low.
- minstret increments when `instr_valid & ~interrupt`. ECALL, EBREAK and MRET count as retired.
- A CSR write to a counter half replaces that half, and that half does not increment that cycle.
- A write to the high half suppresses the carry from the low half that cycle. A write to the low half blocks any carry that cycle.
- Counters wrap from 2^64−1 to 0.

Reset:
- Asserting `rst` at any time clears all state immediately; any in-flight write or trap is lost.
- While `rst` is high, `trap_taken`=0, `trap_pc`=0 and `csr_rdata`=0.

## Timing

- `csr_rdata`, `trap_taken` and `trap_pc` are combinational from the inputs and current state, valid in the same cycle. The core loads `trap_pc` into the PC at the same edge.
- All register updates occur on the rising edge of `clk` at the end of the instruction's cycle. Write-to-read latency is 1 cycle: an instruction in cycle N+1 sees the value written in cycle N.
- A CSR instruction returns the pre-write value. A counter read returns the value before this cycle's increment.
- An MRET immediately after a `csrw mepc` redirects to the new mepc.
- An ECALL immediately after `csrw mtvec` vectors to the new mtvec.
- When `ext_irq` and a CSR write to mstatus occur in the same cycle, the interrupt wins and the write is dropped.
- When `ext_irq` and an ECALL occur in the same cycle, mcause = 32'h8000_000B.

## Test plan

- Reset, then `csrrw` to 0x340 with rs1_data=32'hDEAD_BEEF, then `csrrs` to 0x340 with rs1 field=0 → second read returns 32'hDEAD_BEEF, and mscratch stays unchanged (no write).
- `csrrsi` to 0x300 with zimm=8, then ext_irq=1 with mie=0x800 → `trap_taken`=1, mepc=pc, mcause=32'h8000_000B, mstatus reads 0x1880.
- mtvec=32'h0000_0103, ECALL at pc=0x40 → `trap_pc`=0x100, mepc=0x40, mcause=11. Following MRET → `trap_pc`=0x40, MIE restored.
- Write mcycle=32'hFFFF_FFFF, idle 1 cycle → mcycle=0, mcycleh=1. Write mcycleh=5 on the same cycle the low half wraps → mcycleh=5.
- 10 cycles with `instr_valid` toggling 1,0 → mcycle advances 10, minstret advances 5.
- Assert `rst` mid-ECALL cycle → all CSRs equal their reset values, `trap_taken`=0, and mepc=0 after release.

Source files
------------

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file for the single-cycle RV32 core.
// Executes Zicsr read-modify-write, sequences ECALL/EBREAK/MRET and the
// external interrupt, and holds the 64-bit mcycle/minstret counters.
`timescale 1ns/1ps
module csr_file #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [2:0]  csr_alu_ctr,
  input  logic        csr_we,
  input  logic        csr2reg,
  input  logic        ext_irq,
  output logic [31:0] csr_rdata,
  output logic        trap_taken,
  output logic [31:0] trap_pc
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MINSTRETH= 12'hB82;
  localparam logic [11:0] A_CYCLE    = 12'hC00;
  localparam logic [11:0] A_CYCLEH   = 12'hC80;
  localparam logic [11:0] A_INSTRET  = 12'hC02;
  localparam logic [11:0] A_INSTRETH = 12'hC82;

  localparam logic [31:0] I_ECALL  = 32'h0000_0073;
  localparam logic [31:0] I_EBREAK = 32'h0010_0073;
  localparam logic [31:0] I_MRET   = 32'h3020_0073;

  localparam logic [31:0] CAUSE_EXT_IRQ = 32'h8000_000B;
  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;

  // Architectural state; mtvec/mepc keep their low two bits at zero.
  logic        r_mst_mie;
  logic        r_mst_mpie;
  logic        r_mie_meie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;

  logic [11:0] w_addr;
  logic [4:0]  w_zimm;
  logic [1:0]  w_op;
  logic [31:0] w_src;
  logic [31:0] w_old;
  logic [31:0] w_new;
  logic        w_op_writes;
  logic        w_irq;
  logic        w_ecall;
  logic        w_ebreak;
  logic        w_mret;
  logic        w_trap_entry;
  logic        w_csr_wr;
  logic [31:0] w_cause;

  logic        w_cyc_lo_wr;
  logic        w_cyc_hi_wr;
  logic        w_ret_lo_wr;
  logic        w_ret_hi_wr;
  logic        w_ret_inc;
  logic [32:0] w_cyc_lo_sum;
  logic [32:0] w_ret_lo_sum;
  logic [63:0] w_mcycle_next;
  logic [63:0] w_minstret_next;

  assign w_addr = instr[31:20];
  assign w_zimm = instr[19:15];
  assign w_op   = csr_alu_ctr[2:1];
  assign w_src  = csr_alu_ctr[0] ? {27'b0, w_zimm} : rs1_data;

  // Old-value read mux; unimplemented addresses read zero.
  always_comb begin
    w_old = 32'b0;
    case (w_addr)
      A_MSTATUS:               w_old = {19'b0, 2'b11, 3'b0, r_mst_mpie, 3'b0, r_mst_mie, 3'b0};
      A_MIE:                   w_old = {20'b0, r_mie_meie, 11'b0};
      A_MTVEC:                 w_old = r_mtvec;
      A_MSCRATCH:              w_old = r_mscratch;
      A_MEPC:                  w_old = r_mepc;
      A_MCAUSE:                w_old = r_mcause;
      A_MIP:                   w_old = {20'b0, ext_irq, 11'b0};
      A_MCYCLE,   A_CYCLE:     w_old = r_mcycle[31:0];
      A_MCYCLEH,  A_CYCLEH:    w_old = r_mcycle[63:32];
      A_MINSTRET, A_INSTRET:   w_old = r_minstret[31:0];
      A_MINSTRETH, A_INSTRETH: w_old = r_minstret[63:32];
      default:                 w_old = 32'b0;
    endcase
  end

  // Write/set/clear operand combination; the reserved op leaves the value as is.
  always_comb begin
    w_new       = w_old;
    w_op_writes = 1'b0;
    case (w_op)
      2'b00: begin w_new = w_src;          w_op_writes = 1'b1;            end
      2'b01: begin w_new = w_old | w_src;  w_op_writes = (w_zimm != 5'd0); end
      2'b10: begin w_new = w_old & ~w_src; w_op_writes = (w_zimm != 5'd0); end
      default: begin w_new = w_old;        w_op_writes = 1'b0;            end
    endcase
  end

  // Trap decode: the interrupt pre-empts the instruction, so it blocks the others.
  assign w_irq        = instr_valid & ext_irq & r_mst_mie & r_mie_meie;
  assign w_ecall      = instr_valid & ~w_irq & (instr == I_ECALL);
  assign w_ebreak     = instr_valid & ~w_irq & (instr == I_EBREAK);
  assign w_mret       = instr_valid & ~w_irq & (instr == I_MRET);
  assign w_trap_entry = w_irq | w_ecall | w_ebreak;
  assign w_cause      = w_irq ? CAUSE_EXT_IRQ : (w_ecall ? CAUSE_ECALL : CAUSE_EBREAK);

  assign trap_taken = ~rst & (w_trap_entry | w_mret);
  assign trap_pc    = rst ? 32'b0 : (w_mret ? r_mepc : r_mtvec);
  assign csr_rdata  = (csr2reg & ~rst) ? w_old : 32'b0;

  assign w_csr_wr = csr_we & instr_valid & ~trap_taken & w_op_writes;

  // Counter next-state: a written half takes the new value and stops the carry path.
  always_comb begin
    w_cyc_lo_wr  = w_csr_wr & (w_addr == A_MCYCLE);
    w_cyc_hi_wr  = w_csr_wr & (w_addr == A_MCYCLEH);
    w_ret_lo_wr  = w_csr_wr & (w_addr == A_MINSTRET);
    w_ret_hi_wr  = w_csr_wr & (w_addr == A_MINSTRETH);
    w_ret_inc    = instr_valid & ~w_irq;
    w_cyc_lo_sum = {1'b0, r_mcycle[31:0]} + 33'd1;
    w_ret_lo_sum = {1'b0, r_minstret[31:0]} + {32'b0, w_ret_inc};
    w_mcycle_next[31:0]    = w_cyc_lo_wr ? w_new : w_cyc_lo_sum[31:0];
    w_mcycle_next[63:32]   = w_cyc_hi_wr ? w_new
                           : r_mcycle[63:32] + {31'b0, w_cyc_lo_sum[32] & ~w_cyc_lo_wr};
    w_minstret_next[31:0]  = w_ret_lo_wr ? w_new : w_ret_lo_sum[31:0];
    w_minstret_next[63:32] = w_ret_hi_wr ? w_new
                           : r_minstret[63:32] + {31'b0, w_ret_lo_sum[32] & ~w_ret_lo_wr};
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcycle   <= 64'b0;
      r_minstret <= 64'b0;
    end else begin
      r_mcycle   <= w_mcycle_next;
      r_minstret <= w_minstret_next;
    end
  end

  // Trap entry/return and software writes to the non-counter CSRs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mst_mie  <= 1'b0;
      r_mst_mpie <= 1'b0;
      r_mie_meie <= 1'b0;
      r_mtvec    <= MTVEC_RST & ~32'h3;
      r_mscratch <= 32'b0;
      r_mepc     <= 32'b0;
      r_mcause   <= 32'b0;
    end else if (w_trap_entry) begin
      r_mepc     <= pc & ~32'h3;
      r_mcause   <= w_cause;
      r_mst_mpie <= r_mst_mie;
      r_mst_mie  <= 1'b0;
    end else if (w_mret) begin
      r_mst_mie  <= r_mst_mpie;
      r_mst_mpie <= 1'b1;
    end else if (w_csr_wr) begin
      case (w_addr)
        A_MSTATUS: begin
          r_mst_mie  <= w_new[3];
          r_mst_mpie <= w_new[7];
        end
        A_MIE:      r_mie_meie <= w_new[11];
        A_MTVEC:    r_mtvec    <= w_new & ~32'h3;
        A_MSCRATCH: r_mscratch <= w_new;
        A_MEPC:     r_mepc     <= w_new & ~32'h3;
        A_MCAUSE:   r_mcause   <= w_new;
        default: ;
      endcase
    end
  end

endmodule
